dct_writeback_ctrl: RTL and testbench

//  Schedules write-back of finished 2-D DCT coefficients from the MAC accumulator into output memory.
//  - Each FSM_Control ready pulse marks one finished (u,v) coefficient; this block captures it on that pulse.
//  - The captured value is rounded, scaled and saturated, then queued in a small FIFO.
//  - The FIFO drains to the output RAM under a valid/ack handshake.
//  - Sits between FSM_Control/MAC and the coefficient RAM; back-pressures the FSM via stall.

---
 rtl/dct_writeback_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dct_writeback_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_writeback_ctrl.sv
// rtl/dct_writeback_ctrl.sv - DCT coefficient write-back scheduler (round/scale/saturate, FIFO, memory handshake)
//
// Ports:
//   clock        rising-edge clock
//   reset_MAC    asynchronous active-low reset
//   ready        1-cycle pulse: acc_in/u/v carry a finished coefficient
//   u, v         frequency indices of the finished coefficient
//   acc_in       signed MAC accumulator value
//   mem_ack      memory accepted the current write (only meaningful while wr_en=1)
//   wr_en        write request valid
//   wr_addr      {u,v} coefficient address
//   wr_data      rounded, scaled, saturated coefficient
//   stall        registered FIFO-nearly-full indication to the FSM
//   frame_done   1-cycle pulse after the 64th acknowledged write of a block
//   overflow_err sticky: a ready was dropped because the FIFO was full

module dct_writeback_ctrl #(
    parameter int ACC_W = 22,
    parameter int OUT_W = 12,
    parameter int SHIFT = 3,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_MAC,
    input  logic                    ready,
    input  logic [2:0]              u,
    input  logic [2:0]              v,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic                    mem_ack,
    output logic                    wr_en,
    output logic [5:0]              wr_addr,
    output logic [OUT_W-1:0]        wr_data,
    output logic                    stall,
    output logic                    frame_done,
    output logic                    overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 6 + OUT_W;

    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) <<< (SHIFT-1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     fifo_q [DEPTH];
    logic [EW-1:0]     fifo_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [5:0]        wcnt_q, wcnt_d;
    logic              wr_en_q, wr_en_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0]  wr_data_q, wr_data_d;
    logic              stall_q, stall_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic signed [ACC_W:0] rnd_sum, shifted;
    logic [OUT_W-1:0]      sat_val;
    logic [EW-1:0]         push_entry, head_entry, next_entry;
    logic                  pop, push;

    // Round half up, arithmetic shift, clamp. One extra bit keeps the rounding add from wrapping.
    always_comb begin
        rnd_sum = $signed({acc_in[ACC_W-1], acc_in}) + RND;
        shifted = rnd_sum >>> SHIFT;
        sat_val = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
        push_entry = {u, v, sat_val};
    end

    // The entry being written stays in the FIFO until acknowledged, so count includes it.
    always_comb begin
        pop  = (state_q == ST_WRITE) && mem_ack;
        // A full FIFO still accepts when the head leaves on the same edge.
        push = ready && ((count_q < CW'(DEPTH)) || pop);

        head_entry = fifo_q[rd_ptr_q];
        // After a pop with only the head queued, the entry pushed this edge is bypassed straight out.
        next_entry = (count_q > CW'(1)) ? fifo_q[rd_ptr_q + AW'(1)] : push_entry;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d      = count_q + CW'(push) - CW'(pop);
        stall_d      = (count_d >= CW'(DEPTH-1));
        wcnt_d       = wcnt_q + 6'(pop);
        frame_done_d = pop && (wcnt_q == 6'd63);
        overflow_d   = overflow_q | (ready & ~push);
    end

    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    {wr_addr_d, wr_data_d} = head_entry;
                    wr_en_d = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (pop) begin
                    if ((count_q > CW'(1)) || push) begin
                        {wr_addr_d, wr_data_d} = next_entry;
                    end else begin
                        wr_en_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                wr_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_MAC) begin
        if (!reset_MAC) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wcnt_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            stall_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wcnt_q       <= wcnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            stall_q      <= stall_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign stall        = stall_q;
    assign frame_done   = frame_done_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_dct_writeback_ctrl.sv
// tb/tb_dct_writeback_ctrl.sv - self-checking bench for dct_writeback_ctrl
module tb_dct_writeback_ctrl;

    logic               clock = 1'b0;
    logic               reset_MAC;
    logic               ready;
    logic [2:0]         u, v;
    logic signed [21:0] acc_in;
    logic               mem_ack;
    logic               wr_en;
    logic [5:0]         wr_addr;
    logic [11:0]        wr_data;
    logic               stall, frame_done, overflow_err;

    int checks = 0;
    int failures = 0;

    logic [17:0] got_q [$];
    int          got_cyc [$];
    int          cyc = 0;
    int          fd_cnt = 0;
    int          fd_at = -1;

    always #5 clock = ~clock;

    dct_writeback_ctrl dut (
        .clock(clock), .reset_MAC(reset_MAC), .ready(ready), .u(u), .v(v),
        .acc_in(acc_in), .mem_ack(mem_ack), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .stall(stall), .frame_done(frame_done),
        .overflow_err(overflow_err)
    );

    // Accepted writes are observed mid-cycle; they complete on the following rising edge.
    always @(negedge clock) begin
        cyc++;
        if (reset_MAC === 1'b1) begin
            if (wr_en && mem_ack) begin
                got_q.push_back({wr_addr, wr_data});
                got_cyc.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = got_q.size();
            end
        end
    end

    // Reference: round half up, divide by 8 with floor, clamp to 12-bit signed.
    function automatic logic [11:0] model(input longint acc);
        longint r, s;
        r = acc + 4;
        if (r >= 0) s = r / 8;
        else        s = -((-r + 7) / 8);
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        return s[11:0];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_MAC = 1'b0; ready = 1'b0; mem_ack = 1'b0;
        u = '0; v = '0; acc_in = '0;
        repeat (2) @(posedge clock);
        #1 reset_MAC = 1'b1;
        got_q.delete(); got_cyc.delete();
        fd_cnt = 0; fd_at = -1;
    endtask

    task automatic pulse(input logic [2:0] pu, input logic [2:0] pv, input logic signed [21:0] pa);
        ready = 1'b1; u = pu; v = pv; acc_in = pa;
        @(posedge clock);
        #1 ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_MAC = 1'b0; ready = 1'b0; mem_ack = 1'b0;
        u = '0; v = '0; acc_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 6'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (wr_data !== 12'd0) begin failures++; $display("FAIL reset_wr_data got=%0d exp=0", wr_data); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_err); end
        @(posedge clock);
        #1 reset_MAC = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if ({wr_en, wr_addr, wr_data, stall, frame_done, overflow_err} !== 22'd0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%h exp=0", k,
                         {wr_en, wr_addr, wr_data, stall, frame_done, overflow_err});
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        do_reset();
        mem_ack = 1'b1;
        pulse(3'd2, 3'd5, 22'sd100);
        @(negedge clock);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_latency_early got=%b exp=0", wr_en); end
        @(negedge clock);
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
        checks++; if (wr_addr !== 6'o25) begin failures++; $display("FAIL single_addr got=%o exp=25", wr_addr); end
        checks++; if (wr_data !== 12'd13) begin failures++; $display("FAIL single_data got=%0d exp=13", wr_data); end
        @(negedge clock);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b exp=0", wr_en); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_rounding();
        logic signed [21:0] vals [11];
        logic [11:0]        exps [11];
        bit                 found;
        vals[0] = 22'h3FFFF4; exps[0] = 12'hFFF;
        vals[1] = 22'h1FFFFF; exps[1] = 12'h7FF;
        vals[2] = 22'h200000; exps[2] = 12'h800;
        for (int i = 3; i < 11; i++) begin
            vals[i] = $signed(22'($urandom_range(0, 32767)) - 22'd16384);
            exps[i] = model(longint'(vals[i]));
        end
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 11; i++) begin
            pulse(3'(i), 3'(7 - i), vals[i]);
            found = 0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clock);
                if (wr_en) found = 1;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL round_timeout idx=%0d no wr_en", i);
            end else if (wr_data !== exps[i]) begin
                failures++; $display("FAIL round_data idx=%0d acc=%0d got=%h exp=%h", i, vals[i], wr_data, exps[i]);
            end
            @(posedge clock);
            #1;
        end
        step(2);
    endtask

    task automatic test_backpressure();
        logic [17:0] exp_e [5];
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_e[i] = {3'(i), 3'(7 - i), model(longint'(i * 80 - 100))};
        end
        pulse(3'd0, 3'd7, 22'sd0 - 22'sd100);
        pulse(3'd1, 3'd6, 22'sd80 - 22'sd100);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bp_stall_after2 got=%b exp=0", stall); end
        pulse(3'd2, 3'd5, 22'sd160 - 22'sd100);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL bp_stall_after3 got=%b exp=1", stall); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL bp_no_overflow got=%b exp=0", overflow_err); end
        pulse(3'd3, 3'd4, 22'sd240 - 22'sd100);
        pulse(3'd4, 3'd3, 22'sd320 - 22'sd100);
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", overflow_err); end
        mem_ack = 1'b1;
        step(12);
        mem_ack = 1'b0;
        checks++;
        if (got_q.size() != 4) begin
            failures++; $display("FAIL bp_write_count got=%0d exp=4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== exp_e[i]) begin
                    failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], exp_e[i]);
                end
            end
        end
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%b exp=1", overflow_err); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_q [$];
        logic signed [21:0] a;
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $signed(22'($urandom()));
            exp_q.push_back({3'(i), 3'($urandom_range(0, 7)), 12'd0});
            exp_q[i][11:0] = model(longint'(a));
            pulse(exp_q[i][17:15], exp_q[i][14:12], a);
        end
        step(6);
        checks++;
        if (got_q.size() != 8) begin
            failures++; $display("FAIL b2b_count got=%0d exp=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL b2b_entry idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (got_cyc[7] - got_cyc[0] != 7) begin
                failures++; $display("FAIL b2b_rate span=%0d exp=7", got_cyc[7] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_frame();
        logic [11:0] exp_d [64];
        logic signed [21:0] a;
        logic [5:0] ad;
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 64; i++) begin
            a = $signed(22'($urandom()));
            exp_d[i] = model(longint'(a));
            ad = 6'(i);
            pulse(ad[5:3], ad[2:0], a);
            step(63);
        end
        step(5);
        checks++;
        if (got_q.size() != 64) begin
            failures++; $display("FAIL frame_count got=%0d exp=64", got_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (got_q[i] !== {6'(i), exp_d[i]}) begin
                    failures++; $display("FAIL frame_entry idx=%0d got=%h exp=%h", i, got_q[i], {6'(i), exp_d[i]});
                end
            end
        end
        checks++; if (fd_cnt != 1) begin failures++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
        checks++; if (fd_at != 64) begin failures++; $display("FAIL frame_done_pos got=%0d exp=64", fd_at); end
    endtask

    task automatic test_reset_mid();
        int we_cycles;
        do_reset();
        mem_ack = 1'b0;
        pulse(3'd1, 3'd1, 22'sd8);
        pulse(3'd2, 3'd2, 22'sd16);
        pulse(3'd3, 3'd3, 22'sd24);
        step(1);
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL mid_pre_wr_en got=%b exp=1", wr_en); end
        #2 reset_MAC = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL mid_async_drop got=%b exp=0", wr_en); end
        @(posedge clock);
        #1 reset_MAC = 1'b1;
        mem_ack = 1'b1;
        got_q.delete(); got_cyc.delete();
        we_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (wr_en) we_cycles++;
        end
        checks++; if (we_cycles != 0) begin failures++; $display("FAIL mid_no_writes wr_en_cycles=%0d exp=0", we_cycles); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL mid_no_acks got=%0d exp=0", got_q.size()); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        logic [17:0] exp_q [$];
        logic signed [21:0] a;
        logic [2:0] ru, rv;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            mem_ack = ($urandom_range(0, 3) != 0);
            if (!stall && $urandom_range(0, 2) == 0) begin
                a = $signed(22'($urandom()));
                ru = 3'($urandom_range(0, 7));
                rv = 3'($urandom_range(0, 7));
                ready = 1'b1; u = ru; v = rv; acc_in = a;
                exp_q.push_back({ru, rv, model(longint'(a))});
            end else begin
                ready = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        ready = 1'b0;
        mem_ack = 1'b1;
        step(12);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand_entry idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%b exp=0", overflow_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_frame();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
